// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
// Holds the FSM state encoding, byte-enable helpers and the default ack timeout.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [3:0] BE_WORD     = 4'hF;
   localparam int         TIMEOUT_DEF = 15;

   function automatic logic [3:0] byte_be(input logic [1:0] lo);
      return 4'b0001 << lo;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the 32-bit datapath and the word-organised memory:
// misalignment detect, byte enables, store replication and load lane extraction.
module mem_lane_align
   import dmem_pkg::*;
(
   input  logic        byte_acc,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata_in,
   input  logic        rd_byte,
   input  logic [1:0]  rd_lane,
   input  logic [31:0] rdata_in,
   output logic        misaligned,
   output logic [3:0]  be,
   output logic [31:0] wdata_out,
   output logic [31:0] rdata_out
);

   // Store side: a byte access can target any lane, a word access must be aligned.
   always_comb begin
      misaligned = 1'b0;
      be         = BE_WORD;
      wdata_out  = wdata_in;
      if (byte_acc) begin
         be        = byte_be(addr_lo);
         wdata_out = {4{wdata_in[7:0]}};
      end else begin
         misaligned = (addr_lo != 2'b00);
      end
   end

   // Load side: pick the latched lane and zero-extend it.
   always_comb begin
      rdata_out = rdata_in;
      if (rd_byte) begin
         case (rd_lane)
            2'd0:    rdata_out = {24'd0, rdata_in[7:0]};
            2'd1:    rdata_out = {24'd0, rdata_in[15:8]};
            2'd2:    rdata_out = {24'd0, rdata_in[23:16]};
            2'd3:    rdata_out = {24'd0, rdata_in[31:24]};
            default: rdata_out = 32'd0;
         endcase
      end else begin
         rdata_out = rdata_in;
      end
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns single-cycle datapath loads/stores into a
// req/ack transaction on a variable-latency memory, stalling the core meanwhile.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemWrite,
   input  logic              MemRead,
   input  logic              MemByte,
   input  logic [ADDR_W-1:0] ALUResult,
   input  logic [DATA_W-1:0] WriteData,
   output logic [DATA_W-1:0] ReadData,
   output logic              Stall,
   output logic              MemErr,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_be,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e            state_r, state_n;
   logic [CNT_W-1:0]  cnt_r;
   logic              req_r, we_r, err_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r, rdata_r;
   logic [3:0]        be_r;
   logic [1:0]        lane_r;
   logic              rd_byte_r;

   logic              access_s, stall_s, start_s, mis_s, ack_s, tmo_s;
   logic              misaligned_s;
   logic [3:0]        be_s;
   logic [31:0]       wdata_s, rdata_s;

   mem_lane_align u_align (
      .byte_acc   (MemByte),
      .addr_lo    (ALUResult[1:0]),
      .wdata_in   (WriteData),
      .rd_byte    (rd_byte_r),
      .rd_lane    (lane_r),
      .rdata_in   (mem_rdata),
      .misaligned (misaligned_s),
      .be         (be_s),
      .wdata_out  (wdata_s),
      .rdata_out  (rdata_s)
   );

   assign access_s = MemRead | MemWrite;

   // Next-state decode and the single-cycle event strobes that steer the registers.
   always_comb begin
      state_n = state_r;
      stall_s = 1'b0;
      start_s = 1'b0;
      mis_s   = 1'b0;
      ack_s   = 1'b0;
      tmo_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (access_s) begin
               stall_s = 1'b1;
               if (misaligned_s) begin
                  mis_s   = 1'b1;
                  state_n = DONE;
               end else begin
                  start_s = 1'b1;
                  state_n = REQ;
               end
            end else begin
               state_n = IDLE;
            end
         end
         REQ: begin
            stall_s = 1'b1;
            if (mem_ack) begin
               ack_s   = 1'b1;
               state_n = DONE;
            end else if (cnt_r == CNT_LAST) begin
               tmo_s   = 1'b1;
               state_n = DONE;
            end else begin
               state_n = REQ;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State, latched request and result registers; reset abandons any access in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r   <= IDLE;
         cnt_r     <= '0;
         req_r     <= 1'b0;
         we_r      <= 1'b0;
         be_r      <= 4'h0;
         addr_r    <= '0;
         wdata_r   <= '0;
         rdata_r   <= '0;
         err_r     <= 1'b0;
         lane_r    <= 2'd0;
         rd_byte_r <= 1'b0;
      end else begin
         state_r <= state_n;
         if (start_s) begin
            cnt_r     <= '0;
            req_r     <= 1'b1;
            we_r      <= MemWrite;
            be_r      <= be_s;
            addr_r    <= {ALUResult[ADDR_W-1:2], 2'b00};
            wdata_r   <= wdata_s;
            lane_r    <= ALUResult[1:0];
            rd_byte_r <= MemByte;
            if (MemWrite && MemRead) begin
               rdata_r <= '0;
            end else begin
               rdata_r <= rdata_r;
            end
         end else if (state_r == REQ) begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (ack_s || tmo_s) begin
               req_r <= 1'b0;
               we_r  <= 1'b0;
               be_r  <= 4'h0;
            end
            // Writes leave the last load result in place.
            if (ack_s && !we_r) begin
               rdata_r <= rdata_s;
            end
            if (tmo_s) begin
               rdata_r <= '0;
               err_r   <= 1'b1;
            end
         end
         if (mis_s) begin
            rdata_r <= '0;
            err_r   <= 1'b1;
         end
      end
   end

   assign Stall     = reset & stall_s;
   assign ReadData  = rdata_r;
   assign MemErr    = err_r;
   assign mem_req   = req_r;
   assign mem_we    = we_r;
   assign mem_addr  = addr_r;
   assign mem_wdata = wdata_r;
   assign mem_be    = be_r;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: the bench plays datapath and memory, predicting each
// transaction's stall/request pattern and result from the access rules.
module tb_dmem_ctrl;

   localparam int TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemWrite, MemRead, MemByte;
   logic [31:0] ALUResult, WriteData, ReadData;
   logic        Stall, MemErr;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   int tests = 0;
   int fails = 0;

   // Model state: last committed load value and sticky error.
   logic [31:0] m_rd;
   logic        m_err;

   dmem_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .MemWrite  (MemWrite),
      .MemRead   (MemRead),
      .MemByte   (MemByte),
      .ALUResult (ALUResult),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .Stall     (Stall),
      .MemErr    (MemErr),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [3:0] m_be(input logic b, input logic [1:0] lo);
      return b ? (4'b0001 << lo) : 4'hF;
   endfunction

   function automatic logic [31:0] m_wd(input logic b, input logic [31:0] w);
      return b ? {4{w[7:0]}} : w;
   endfunction

   function automatic logic [31:0] m_lane(input logic [31:0] r, input logic [1:0] lo);
      return (r >> (8 * lo)) & 32'h0000_00FF;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         MemRead   = 1'b0;
         MemWrite  = 1'b0;
         mem_ack   = 1'($urandom_range(0, 1));
         mem_rdata = $urandom;
         @(negedge clk);
         chk("idle_stall", Stall, 32'd0);
         chk("idle_req", mem_req, 32'd0);
         chk("idle_rdata", ReadData, m_rd);
         chk("idle_err", MemErr, m_err);
         @(posedge clk); #1;
      end
      mem_ack = 1'b0;
   endtask

   // One datapath instruction; d is the REQ cycle (0-based) carrying mem_ack.
   task automatic run_txn(input logic rd, input logic wr, input logic by,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdat, input int d);
      logic mis, tmo;
      int   r;
      mis = !by && (addr[1:0] != 2'b00);
      tmo = 1'b0;
      MemRead = rd; MemWrite = wr; MemByte = by;
      ALUResult = addr; WriteData = wd; mem_rdata = rdat; mem_ack = 1'b0;
      @(negedge clk);
      chk("c0_stall", Stall, 32'd1);
      chk("c0_req", mem_req, 32'd0);
      @(posedge clk); #1;
      if (!mis) begin
         tmo = (d >= TIMEOUT);
         r   = tmo ? TIMEOUT : d + 1;
         for (int j = 0; j < r; j++) begin
            mem_ack = (j == d);
            @(negedge clk);
            chk("req_stall", Stall, 32'd1);
            chk("req_req", mem_req, 32'd1);
            chk("req_addr", mem_addr, {addr[31:2], 2'b00});
            chk("req_we", mem_we, 32'(wr));
            chk("req_be", mem_be, 32'(m_be(by, addr[1:0])));
            if (wr) chk("req_wdata", mem_wdata, m_wd(by, wd));
            @(posedge clk); #1;
         end
      end
      if (mis || tmo) begin
         m_rd  = 32'd0;
         m_err = 1'b1;
      end else if (rd && wr) begin
         m_rd = 32'd0;
      end else if (rd) begin
         m_rd = by ? m_lane(rdat, addr[1:0]) : rdat;
      end
      // DONE: strobes still held by the same instruction; a late ack must be ignored.
      mem_ack   = tmo;
      mem_rdata = ~rdat;
      @(negedge clk);
      chk("done_stall", Stall, 32'd0);
      chk("done_req", mem_req, 32'd0);
      chk("done_rdata", ReadData, m_rd);
      chk("done_err", MemErr, m_err);
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      MemRead = 1'b0; MemWrite = 1'b0; MemByte = 1'b0;
      ALUResult = 32'd0; WriteData = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
      m_rd = 32'd0; m_err = 1'b0;
      MemRead = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_stall", Stall, 32'd0);
      chk("rst_req", mem_req, 32'd0);
      chk("rst_be", mem_be, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_rdata", ReadData, 32'd0);
      chk("rst_err", MemErr, 32'd0);
      MemRead = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      idle(2);

      // Model pins against hand-computed values.
      chk("pin_be_b3", 32'(m_be(1'b1, 2'd3)), 32'h0000_0008);
      chk("pin_wd_rep", m_wd(1'b1, 32'h0000_00A5), 32'hA5A5_A5A5);
      chk("pin_lane2", m_lane(32'h1122_3344, 2'd2), 32'h0000_0022);

      run_txn(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'd0, 32'hCAFE_F00D, 2);
      chk("wload_lit", ReadData, 32'hCAFE_F00D);
      run_txn(1'b0, 1'b1, 1'b1, 32'h0000_0203, 32'h0000_00A5, 32'h0, 0);
      chk("bstore_keeps_rd", ReadData, 32'hCAFE_F00D);
      run_txn(1'b1, 1'b0, 1'b1, 32'h0000_0402, 32'd0, 32'h1122_3344, 1);
      chk("bload_lit", ReadData, 32'h0000_0022);
      run_txn(1'b1, 1'b0, 1'b0, 32'h0000_0101, 32'd0, 32'h0, 0);
      chk("mis_err_lit", MemErr, 32'd1);
      run_txn(1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'd0, 32'h0000_55AA, 0);
      chk("after_mis_lit", ReadData, 32'h0000_55AA);
      run_txn(1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'd0, 32'h1234_5678, TIMEOUT + 3);
      idle(2);
      run_txn(1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'hDEAD_BEEF, 32'h7777_7777, 0);
      run_txn(1'b1, 1'b0, 1'b0, 32'h0000_0504, 32'd0, 32'h0BAD_CAFE, TIMEOUT - 1);

      // Reset during REQ abandons the access.
      MemRead = 1'b1; MemWrite = 1'b0; MemByte = 1'b0;
      ALUResult = 32'h0000_0600; mem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("pre_rst_req", mem_req, 32'd1);
      reset = 1'b0; MemRead = 1'b0;
      @(negedge clk);
      chk("midrst_req", mem_req, 32'd0);
      chk("midrst_stall", Stall, 32'd0);
      chk("midrst_rdata", ReadData, 32'd0);
      chk("midrst_err", MemErr, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      m_rd = 32'd0; m_err = 1'b0;
      mem_ack = 1'b1;
      @(negedge clk);
      chk("late_ack_req", mem_req, 32'd0);
      chk("late_ack_rd", ReadData, 32'd0);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      run_txn(1'b1, 1'b0, 1'b0, 32'h0000_0700, 32'd0, 32'h0F0F_1234, 1);
      chk("post_rst_lit", ReadData, 32'h0F0F_1234);

      for (int t = 0; t < 150; t++) begin
         int op;
         logic rd, wr, by;
         logic [31:0] a;
         int d;
         op = $urandom_range(0, 3);
         rd = (op != 1);
         wr = (op == 1) || (op == 2);
         by = 1'($urandom_range(0, 1));
         a  = $urandom;
         if (!by && ($urandom_range(0, 3) != 0)) a[1:0] = 2'b00;
         d  = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 18) : $urandom_range(0, 4);
         run_txn(rd, wr, by, a, $urandom, $urandom, d);
         idle($urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the single-cycle datapath.
- Consumes the datapath's address (ALUResult), WriteData, MemWrite and MemtoReg (used as the read strobe). Returns ReadData.
- Bridges to an external variable-latency memory over a req/ack handshake.
- Asserts Stall to freeze the PC and register-file writes until the access completes. Handles byte accesses, misalignment and ack timeout.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (fixed 32; byte lanes assume 4)
TIMEOUT, 15, cycles in REQ without mem_ack before the access is aborted

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous active-low reset (asserted when 0)
MemWrite  in  1  store request from datapath
MemRead  in  1  load request (datapath MemtoReg)
MemByte  in  1  1 = byte access, 0 = word access
ALUResult  in  ADDR_W  byte address
WriteData  in  DATA_W  store data
ReadData  out  DATA_W  load data to datapath result mux
Stall  out  1  freeze datapath (combinational)
MemErr  out  1  sticky error flag (misaligned or timeout)
mem_req  out  1  external request, held until ack
mem_we  out  1  external write enable
mem_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
mem_wdata  out  DATA_W  store data, byte replicated when MemByte
mem_be  out  4  byte enables
mem_ack  in  1  external completion, one-cycle pulse
mem_rdata  in  DATA_W  read data, valid with mem_ack

Behaviour:
- Reset (reset==0 at a rising edge): state=IDLE, counter=0. mem_req, mem_we, mem_be=0. mem_addr, mem_wdata, ReadData=0. MemErr=0. Stall is forced 0 while reset==0.
- Reset mid-operation aborts the access. mem_req is 0 after that edge, no retry is issued, and a late mem_ack is ignored.
- States are IDLE, REQ and DONE.
- IDLE:
  - access = MemRead|MemWrite.
  - If access: Stall=1. Latch address, data, MemByte and the op (write wins when both are set; ReadData=0 for that case). Go to REQ next edge.
  - If misaligned (MemByte=0 and addr[1:0]!=0): no external request is made. Set MemErr, ReadData=0, go directly to DONE (one stall cycle).
- REQ:
  - Outputs: mem_req=1; mem_we, mem_addr, mem_wdata, mem_be from latched values; Stall=1; counter increments each cycle.
  - On mem_ack: load ReadData (reads only), drop mem_req, go to DONE. ReadData is unchanged for writes.
  - If counter reaches TIMEOUT with no ack: drop mem_req, set MemErr, ReadData=0, go to DONE.
- DONE:
  - Stall=0 for exactly one cycle, so the datapath commits using the registered ReadData. Always returns to IDLE.
  - The same instruction's strobes in DONE do not retrigger.
- mem_ack outside REQ is ignored.
- Latency: with the access presented in cycle 0 and ack in cycle 1, DONE is cycle 2. Minimum 2 stall cycles per access; 1 for misaligned.
- Byte write: mem_be=4'b0001<<addr[1:0], mem_wdata={4{WriteData[7:0]}}.
- Word write: mem_be=4'hF.
- Byte read: ReadData = zero-extended lane addr[1:0] of mem_rdata.
- MemErr is sticky until reset. A later access proceeds normally.
- ReadData holds its value between accesses.

Decomposition:
- Package dmem_pkg holds:
  - state enum {IDLE,REQ,DONE}
  - BE_WORD=4'hF
  - default TIMEOUT constant
  - function computing byte enables from addr[1:0]
- One natural sub-module, mem_lane_align (combinational). It handles misalignment detect, byte enables, write-data replication and read-lane extraction/zero-extension.

Test Plan:
- Word load addr 0x100, mem_ack 3 cycles after mem_req with mem_rdata 0xCAFEF00D -> mem_addr=0x100, mem_be=F, Stall high 4 cycles; in DONE ReadData=0xCAFEF00D, Stall=0.
- Byte store addr 0x203, WriteData 0x000000A5, immediate ack -> mem_be=4'b1000, mem_wdata=0xA5A5A5A5, mem_we=1, Stall high 2 cycles.
- Byte load addr 0x402, mem_rdata 0x11223344 -> ReadData=0x00000022.
- Word load addr 0x101 -> mem_req never asserted, MemErr=1, ReadData=0, one stall cycle; the following aligned access completes with MemErr still 1.
- No ack for TIMEOUT=15 cycles -> mem_req drops, MemErr=1, DONE with ReadData=0; ack arriving afterwards is ignored.
- reset=0 while in REQ -> next edge mem_req=0, state IDLE, MemErr=0, ReadData=0; after release, a load with ack completes normally.
